ex_muldiv_ctrl: RTL and testbench
=================================

EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; only 32 is supported.
REQ-002 SHALL have clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have ex_valid  input  1  EX stage holds a valid instruction.
REQ-005 SHALL have ex_is_mul_inst  input  1  EX instruction is MUL/MULH/MULHSU/MULHU.
REQ-006 SHALL have ex_is_div_inst  input  1  EX instruction is DIV/DIVU/REM/REMU.
REQ-007 SHALL have ex_md_op  input  2  funct3[1:0]; mul: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; div: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 SHALL have ex_rs1_data / ex_rs2_data  input  XLEN each  operands.
REQ-009 SHALL have mem_allowin  input  1  MEM stage accepts a new instruction this cycle.
REQ-010 SHALL have ex_flush  input  1  kill the in-flight EX instruction.
REQ-011 SHALL have ex_mul_done / ex_div_done  output  1 each  result valid, held until the instruction leaves EX.
REQ-012 SHALL have ex_md_res  output  XLEN  result, valid while either done output is high.
REQ-013 SHALL have md_busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, MUL_RUN, DIV_RUN and DONE.
REQ-015 Start condition: state IDLE and ex_valid and (ex_is_mul_inst or ex_is_div_inst) and not ex_flush; on start SHALL latch the op, the operand signs and the operand magnitudes; rs1/rs2 are don't-care afterwards.
REQ-016 Operand signedness: signed for MULH/DIV/REM, rs1 only for MULHSU, unsigned otherwise; a signed operand SHALL be replaced by its absolute value, with the result sign = XOR of the operand signs (REM: sign of rs1).
REQ-017 Transitions on start: mul -> MUL_RUN; div with a normal divisor -> DIV_RUN; special div (REQ-021) -> DONE directly.
REQ-018 MUL_RUN SHALL perform a 32-iteration radix-2 shift-add into a 64-bit product with a 6-bit counter; after the 32nd iteration -> DONE.
REQ-019 DIV_RUN SHALL perform a 32-iteration restoring division producing a 32-bit quotient and 32-bit remainder; after the 32nd iteration -> DONE.
REQ-020 Latency: for a normal op started at cycle T, done SHALL be high from T+33 onward; for a special div started at cycle T, done SHALL be high from T+1 onward.
REQ-021 Division by zero SHALL give quotient 0xFFFFFFFF and remainder rs1; signed overflow (rs1 0x80000000, rs2 0xFFFFFFFF, DIV/REM) SHALL give quotient 0x80000000 and remainder 0.
REQ-022 Result select: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder; sign fixup (two's-complement negate of the 64-bit product or the quotient/remainder) SHALL be applied before the select; unsigned ops SHALL get no fixup.
REQ-023 In DONE, ex_mul_done SHALL equal (latched op is mul) and ex_div_done SHALL equal (latched op is div); both SHALL be 0 in every other state.
REQ-024 DONE -> IDLE SHALL occur when mem_allowin = 1; otherwise the FSM SHALL hold DONE with ex_md_res stable.
REQ-025 A start SHALL NOT occur in the same cycle as DONE -> IDLE; the next instruction starts at the earliest one cycle later.
REQ-026 ex_flush SHALL force the FSM to IDLE in any state on the next edge, with done outputs 0 that cycle and after; ex_flush takes priority over start and over mem_allowin.
REQ-027 ex_md_res SHALL be 0 when not in DONE.
REQ-028 When ex_is_mul_inst and ex_is_div_inst are both set, mul SHALL take priority.

Reset
REQ-029 With rst_n low, the following SHALL hold immediately (asynchronous): state IDLE, counter 0, product/quotient/remainder registers 0, all outputs 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse after release; the first start after release SHALL behave as from a fresh reset.

Verification
REQ-031 MULH: rs1 0xFFFFFFFE (-2), rs2 0x00000003, mem_allowin 1, start at T -> ex_mul_done high at T+33, ex_md_res 0xFFFFFFFF; IDLE at T+34.
REQ-032 DIV: rs1 0x80000000, rs2 0xFFFFFFFF -> ex_div_done at T+1, result 0x80000000; REMU with rs1 7, rs2 0 -> result 7 at T+1.
REQ-033 REM: rs1 -7, rs2 2 -> 0xFFFFFFFF at T+33; DIVU: rs1 0xFFFFFFFF, rs2 2 -> 0x7FFFFFFF.
REQ-034 Backpressure: mem_allowin low for 5 cycles after done -> done and result held stable for all 5; IDLE one cycle after mem_allowin rises.
REQ-035 ex_flush at T+10 of a MUL -> IDLE at T+11, no done; a new DIV started at T+12 completes at T+45.
REQ-036 rst_n low at T+20 of a DIV -> outputs 0 immediately; after release the next MULHU of 0xFFFFFFFF by 0xFFFFFFFF -> 0xFFFFFFFE.

Source files
------------

// File: rtl/ex_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// ex_muldiv_ctrl
//   Multi-cycle multiply/divide unit for the EX stage of a RV32M pipeline.
//   A radix-2 shift-add multiplier and a restoring divider share one FSM
//   (IDLE -> MUL_RUN/DIV_RUN -> DONE -> IDLE). Operands are latched as
//   magnitudes; the result sign is fixed up once the iterations are over.
//   Divide-by-zero and signed overflow finish in a single cycle.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   ex_valid            : EX stage holds a valid instruction
//   ex_is_mul_inst      : instruction is MUL/MULH/MULHSU/MULHU
//   ex_is_div_inst      : instruction is DIV/DIVU/REM/REMU
//   ex_md_op            : funct3[1:0] selecting the variant
//   ex_rs1/rs2_data     : operands, sampled only on start
//   mem_allowin         : MEM accepts the finished instruction
//   ex_flush            : kill the in-flight instruction
//   ex_mul/div_done     : result valid, held until the instruction leaves
//   ex_md_res           : result, zero outside DONE
//   md_busy             : FSM not in IDLE
// ---------------------------------------------------------------------------
module ex_muldiv_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_is_mul_inst,
   input  logic            ex_is_div_inst,
   input  logic [1:0]      ex_md_op,
   input  logic [XLEN-1:0] ex_rs1_data,
   input  logic [XLEN-1:0] ex_rs2_data,
   input  logic            mem_allowin,
   input  logic            ex_flush,
   output logic            ex_mul_done,
   output logic            ex_div_done,
   output logic [XLEN-1:0] ex_md_res,
   output logic            md_busy
);

   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [1:0]        op_q, op_d;
   logic              is_mul_q, is_mul_d;
   logic              neg_q, neg_d;
   logic              mul_done_q, mul_done_d;
   logic              div_done_q, div_done_d;
   logic [XLEN-1:0]   res_q, res_d;

   // operand decode (mul wins when both instruction flags are set)
   logic            mul_sel, s1_signed, s2_signed, neg1, neg2;
   logic            start, div_zero, div_ovf;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   mul_sum;
   logic [XLEN+1:0] div_diff;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0] quo_fix, rem_fix;

   assign mul_sel   = ex_is_mul_inst;
   assign s1_signed = mul_sel ? (ex_md_op == 2'b01 || ex_md_op == 2'b10) : ~ex_md_op[0];
   assign s2_signed = mul_sel ? (ex_md_op == 2'b01) : ~ex_md_op[0];
   assign neg1      = s1_signed & ex_rs1_data[XLEN-1];
   assign neg2      = s2_signed & ex_rs2_data[XLEN-1];
   assign a_mag     = neg1 ? (~ex_rs1_data + 1'b1) : ex_rs1_data;
   assign b_mag     = neg2 ? (~ex_rs2_data + 1'b1) : ex_rs2_data;
   assign start     = (state_q == IDLE) & ex_valid & (ex_is_mul_inst | ex_is_div_inst) & ~ex_flush;
   assign div_zero  = (ex_rs2_data == '0);
   assign div_ovf   = ~ex_md_op[0] & (ex_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (ex_rs2_data == '1);

   // one shift-add step: conditionally add multiplicand to the upper half,
   // then shift the whole product right; the carry lands in bit 63
   assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
   // one restoring step: trial-subtract divisor from {rem, next dividend bit}
   assign div_diff = {1'b0, rem_q, quo_q[XLEN-1]} - {2'b00, b_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      b_d      = b_q;
      op_d     = op_q;
      is_mul_d = is_mul_q;
      neg_d    = neg_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d     = ex_md_op;
               is_mul_d = mul_sel;
               b_d      = b_mag;
               cnt_d    = '0;
               if (mul_sel) begin
                  prod_d  = {{XLEN{1'b0}}, a_mag};
                  neg_d   = neg1 ^ neg2;
                  state_d = MUL_RUN;
               end else if (div_zero) begin
                  // results are final as stored: no sign fixup
                  quo_d   = '1;
                  rem_d   = ex_rs1_data;
                  neg_d   = 1'b0;
                  state_d = DONE;
               end else if (div_ovf) begin
                  quo_d   = {1'b1, {(XLEN-1){1'b0}}};
                  rem_d   = '0;
                  neg_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  quo_d   = a_mag;
                  rem_d   = '0;
                  // remainder takes the dividend's sign
                  neg_d   = ex_md_op[1] ? neg1 : (neg1 ^ neg2);
                  state_d = DIV_RUN;
               end
            end
         end
         MUL_RUN: begin
            prod_d = {mul_sum, prod_q[XLEN-1:1]};
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == 6'(XLEN-1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DIV_RUN: begin
            if (!div_diff[XLEN+1]) begin
               rem_d = div_diff[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(XLEN-1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (mem_allowin) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (ex_flush) state_d = IDLE;
   end

   // Outputs are registered: computed from the next datapath values so they
   // are valid in the first DONE cycle and stay stable while DONE is held.
   assign prod_fix = neg_d ? (~prod_d + 1'b1) : prod_d;
   assign quo_fix  = neg_d ? (~quo_d + 1'b1) : quo_d;
   assign rem_fix  = neg_d ? (~rem_d + 1'b1) : rem_d;

   always_comb begin
      mul_done_d = 1'b0;
      div_done_d = 1'b0;
      res_d      = '0;
      if (state_d == DONE) begin
         mul_done_d = is_mul_d;
         div_done_d = ~is_mul_d;
         if (is_mul_d)
            res_d = (op_d == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
         else
            res_d = op_d[1] ? rem_fix : quo_fix;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         prod_q     <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         b_q        <= '0;
         op_q       <= '0;
         is_mul_q   <= 1'b0;
         neg_q      <= 1'b0;
         mul_done_q <= 1'b0;
         div_done_q <= 1'b0;
         res_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prod_q     <= prod_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         b_q        <= b_d;
         op_q       <= op_d;
         is_mul_q   <= is_mul_d;
         neg_q      <= neg_d;
         mul_done_q <= mul_done_d;
         div_done_q <= div_done_d;
         res_q      <= res_d;
      end
   end

   assign ex_mul_done = mul_done_q;
   assign ex_div_done = div_done_q;
   assign ex_md_res   = res_q;
   assign md_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_ctrl
//   Directed bench for ex_muldiv_ctrl. Each started instruction pushes its
//   expected result, done kind and latency (from a behavioural model using
//   native SystemVerilog arithmetic) onto a queue; the entry is popped and
//   compared when the DUT raises a done output.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_ctrl;

   typedef struct {
      bit          is_mul;
      logic [31:0] res;
      int          lat;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_is_mul_inst, ex_is_div_inst;
   logic [1:0]  ex_md_op;
   logic [31:0] ex_rs1_data, ex_rs2_data;
   logic        mem_allowin, ex_flush;
   logic        ex_mul_done, ex_div_done, md_busy;
   logic [31:0] ex_md_res;

   int   compared   = 0;
   int   mismatched = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   ex_muldiv_ctrl #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
      .ex_is_mul_inst(ex_is_mul_inst), .ex_is_div_inst(ex_is_div_inst),
      .ex_md_op(ex_md_op), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .mem_allowin(mem_allowin), .ex_flush(ex_flush),
      .ex_mul_done(ex_mul_done), .ex_div_done(ex_div_done),
      .ex_md_res(ex_md_res), .md_busy(md_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input bit is_mul, input logic [1:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
      longint      sp;
      logic [63:0] up;
      int          sa, sb;
      bit          ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      model = '0;
      if (is_mul) begin
         case (op)
            2'b00: begin up = {32'b0, a} * {32'b0, b}; model = up[31:0]; end
            2'b01: begin sp = longint'($signed(a)) * longint'($signed(b)); up = sp; model = up[63:32]; end
            2'b10: begin sp = longint'($signed(a)) * longint'({32'b0, b}); up = sp; model = up[63:32]; end
            default: begin up = {32'b0, a} * {32'b0, b}; model = up[63:32]; end
         endcase
      end else begin
         case (op)
            2'b00: model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            2'b01: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: model = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: model = (b == 0) ? a : a % b;
         endcase
      end
   endfunction

   // drive one start cycle; returns right after the edge that samples it
   task automatic start_op(input bit is_mul, input bit is_div, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input bit push, input string tag);
      exp_t e;
      bit   mul_eff;
      mul_eff = is_mul;
      @(negedge clk);
      ex_valid = 1'b1; ex_is_mul_inst = is_mul; ex_is_div_inst = is_div;
      ex_md_op = op; ex_rs1_data = a; ex_rs2_data = b;
      if (push) begin
         e.is_mul = mul_eff;
         e.res    = model(mul_eff, op, a, b);
         e.lat    = (!mul_eff && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
         e.tag    = tag;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      ex_valid = 1'b0; ex_is_mul_inst = 1'b0; ex_is_div_inst = 1'b0;
      ex_rs1_data = $urandom; ex_rs2_data = $urandom;
   endtask

   // count cycles after the start edge until done, then compare against the queue
   task automatic wait_done();
      exp_t e;
      int   n;
      bit   seen;
      seen = 1'b0;
      for (n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (ex_mul_done || ex_div_done) begin seen = 1'b1; break; end
      end
      if (sb_q.size() == 0) begin
         compared++; mismatched++;
         $error("FAIL scoreboard: observed empty queue expected entry");
      end else begin
         e = sb_q.pop_front();
         chk({e.tag, " seen"}, 32'(seen), 32'd1);
         chk({e.tag, " latency"}, 32'(n), 32'(e.lat));
         chk({e.tag, " mul_done"}, 32'(ex_mul_done), 32'(e.is_mul));
         chk({e.tag, " div_done"}, 32'(ex_div_done), 32'(!e.is_mul));
         chk({e.tag, " result"}, ex_md_res, e.res);
         $display("txn %-10s lat=%0d res=%h exp=%h", e.tag, n, ex_md_res, e.res);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " busy"}, 32'(md_busy), 32'd0);
      chk({tag, " done"}, 32'({ex_mul_done, ex_div_done}), 32'd0);
      chk({tag, " res0"}, ex_md_res, 32'd0);
   endtask

   task automatic do_op(input bit is_mul, input bit is_div, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input string tag);
      start_op(is_mul, is_div, op, a, b, 1'b1, tag);
      wait_done();
      @(negedge clk);
      check_idle({tag, " after"});
   endtask

   logic [31:0] held;
   bit          any_done;

   initial begin
      rst_n = 1'b0; ex_valid = 1'b0; ex_is_mul_inst = 1'b0; ex_is_div_inst = 1'b0;
      ex_md_op = 2'b00; ex_rs1_data = '0; ex_rs2_data = '0;
      mem_allowin = 1'b1; ex_flush = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;

      // directed operations (mul / div / specials / mul priority)
      do_op(1, 0, 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, "MULH");
      do_op(0, 1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "DIV_OVF");
      do_op(0, 1, 2'b11, 32'd7, 32'd0, "REMU_Z");
      do_op(0, 1, 2'b10, 32'hFFFF_FFF9, 32'd2, "REM");
      do_op(0, 1, 2'b01, 32'hFFFF_FFFF, 32'd2, "DIVU");
      do_op(1, 0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, "MUL");
      do_op(1, 0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");
      do_op(0, 1, 2'b00, 32'hFFFF_FF9C, 32'd7, "DIV_NEG");
      do_op(0, 1, 2'b10, 32'd100, 32'hFFFF_FFF9, "REM_NEG");
      do_op(0, 1, 2'b00, 32'd5, 32'd0, "DIV_Z");
      do_op(0, 1, 2'b10, 32'hFFFF_FFFB, 32'd0, "REM_Z");
      do_op(0, 1, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "DIVU_BIG");
      do_op(1, 1, 2'b10, 32'h8000_0000, 32'h0000_0003, "PRIO");
      for (int i = 0; i < 8; i++) begin
         logic [2:0]  sel;
         logic [31:0] ra, rb;
         sel = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         do_op(!sel[2], sel[2], sel[1:0], ra, rb, "RAND");
      end

      // backpressure: done and result held while MEM refuses
      mem_allowin = 1'b0;
      start_op(0, 1, 2'b01, 32'd1000, 32'd7, 1'b1, "BP_DIVU");
      wait_done();
      held = ex_md_res;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp done", 32'(ex_div_done), 32'd1);
         chk("bp res", ex_md_res, held);
      end
      mem_allowin = 1'b1;
      @(negedge clk);
      check_idle("bp release");

      // flush in the middle of a multiply, then a divide right behind it
      start_op(1, 0, 2'b00, 32'd9, 32'd9, 1'b0, "FLUSHED");
      repeat (10) @(negedge clk);
      ex_flush = 1'b1;
      @(negedge clk);
      check_idle("flush");
      ex_flush = 1'b0;
      do_op(0, 1, 2'b00, 32'hFFFF_FF00, 32'd16, "DIV_AFTER");

      // asynchronous reset in the middle of a divide
      start_op(0, 1, 2'b00, 32'd12345, 32'd11, 1'b0, "RST_DIV");
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle("async rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      any_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ex_mul_done || ex_div_done || md_busy) any_done = 1'b1;
      end
      chk("no done after rst", 32'(any_done), 32'd0);
      do_op(1, 0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU");

      chk("queue empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
